// File: rtl/systolic_2x2_ctrl.sv
// Sequencer for the 2x2 systolic multiply array: latches A/B on start, clears the array,
// feeds skewed row/column streams, waits for completion and returns C on a valid/ready port.
module systolic_2x2_ctrl #(
    parameter int DW      = 32,
    parameter int RW      = 64,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*DW-1:0]   a_flat,
    input  logic [4*DW-1:0]   b_flat,
    output logic              busy,
    output logic              arr_rst,
    output logic              arr_load,
    output logic [DW-1:0]     arr_row0,
    output logic [DW-1:0]     arr_row1,
    output logic [DW-1:0]     arr_col0,
    output logic [DW-1:0]     arr_col1,
    input  logic [4*RW-1:0]   arr_res,
    input  logic [3:0]        arr_carry,
    input  logic              arr_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [4*RW-1:0]   res_c,
    output logic [3:0]        res_carry,
    output logic              res_timeout
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TIMER_MAX  = {TW{1'b1}};
    localparam logic [TW-1:0]   TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]   D_ZERO     = {DW{1'b0}};
    localparam logic [4*RW-1:0] C_ZERO     = {(4*RW){1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_FEED = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t           state_r;
    logic [1:0]       step_r;
    logic [TW-1:0]    timer_r;
    logic [4*DW-1:0]  a_r;
    logic [4*DW-1:0]  b_r;

    logic [DW-1:0] a00_s, a01_s, a10_s, a11_s;
    logic [DW-1:0] b00_s, b01_s, b10_s, b11_s;

    assign a00_s = a_r[0*DW +: DW];
    assign a01_s = a_r[1*DW +: DW];
    assign a10_s = a_r[2*DW +: DW];
    assign a11_s = a_r[3*DW +: DW];
    assign b00_s = b_r[0*DW +: DW];
    assign b01_s = b_r[1*DW +: DW];
    assign b10_s = b_r[2*DW +: DW];
    assign b11_s = b_r[3*DW +: DW];

    // Sequencer FSM; every output is registered with the value of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            step_r      <= 2'd0;
            timer_r     <= {TW{1'b0}};
            a_r         <= {(4*DW){1'b0}};
            b_r         <= {(4*DW){1'b0}};
            busy        <= 1'b0;
            arr_rst     <= 1'b1;
            arr_load    <= 1'b0;
            arr_row0    <= D_ZERO;
            arr_row1    <= D_ZERO;
            arr_col0    <= D_ZERO;
            arr_col1    <= D_ZERO;
            res_valid   <= 1'b0;
            res_c       <= C_ZERO;
            res_carry   <= 4'd0;
            res_timeout <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a_flat;
                        b_r     <= b_flat;
                        busy    <= 1'b1;
                        arr_rst <= 1'b1;
                        state_r <= ST_CLR;
                    end else begin
                        arr_rst <= 1'b0;
                    end
                end
                ST_CLR: begin
                    arr_rst  <= 1'b0;
                    arr_load <= 1'b1;
                    arr_row0 <= a00_s;
                    arr_row1 <= D_ZERO;
                    arr_col0 <= b00_s;
                    arr_col1 <= D_ZERO;
                    step_r   <= 2'd0;
                    state_r  <= ST_FEED;
                end
                ST_FEED: begin
                    // step_r names the step currently on the array inputs
                    case (step_r)
                        2'd0: begin
                            arr_row0 <= a01_s;
                            arr_row1 <= a10_s;
                            arr_col0 <= b10_s;
                            arr_col1 <= b01_s;
                            step_r   <= 2'd1;
                        end
                        2'd1: begin
                            arr_row0 <= D_ZERO;
                            arr_row1 <= a11_s;
                            arr_col0 <= D_ZERO;
                            arr_col1 <= b11_s;
                            step_r   <= 2'd2;
                        end
                        default: begin
                            arr_load <= 1'b0;
                            arr_row0 <= D_ZERO;
                            arr_row1 <= D_ZERO;
                            arr_col0 <= D_ZERO;
                            arr_col1 <= D_ZERO;
                            timer_r  <= {TW{1'b0}};
                            step_r   <= 2'd0;
                            state_r  <= ST_WAIT;
                        end
                    endcase
                end
                ST_WAIT: begin
                    if (timer_r != TIMER_MAX) begin
                        timer_r <= timer_r + TIMER_ONE;
                    end else begin
                        timer_r <= timer_r;
                    end
                    if (arr_done) begin
                        res_c       <= arr_res;
                        res_carry   <= arr_carry;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        state_r     <= ST_RESP;
                    end else if (timer_r == TIMER_LAST) begin
                        res_c       <= C_ZERO;
                        res_carry   <= 4'd0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    arr_rst   <= 1'b1;
                    arr_load  <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
